// File: rtl/memory_sub_system_param.sv
// Shared geometry and types for the cache subsystem.
package memory_sub_system_param;

  localparam int TAG_LENGTH      = 8;
  localparam int INDEX_LENGTH    = 3;
  localparam int NUM_CACHE_LINES = 1 << INDEX_LENGTH;
  localparam int OFFSET_LENGTH   = 4;
  localparam int ADDR_WIDTH      = TAG_LENGTH + INDEX_LENGTH + OFFSET_LENGTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    UPDATE = 2'd3
  } cache_state_t;

  // Field extraction from a CPU address {tag, index, offset}.
  function automatic logic [TAG_LENGTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1 -: TAG_LENGTH];
  endfunction

  function automatic logic [INDEX_LENGTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    return a[OFFSET_LENGTH +: INDEX_LENGTH];
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins, increment only below the all-ones ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (inc && (cnt_q != {WIDTH{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache lookup/refill controller in front of tag_mem.
// Owns the per-line valid bits, runs a single-outstanding refill and
// keeps saturating hit/miss statistics.
module dm_cache_ctrl
  import memory_sub_system_param::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic                    flush,
  output logic                    cpu_ready,
  output logic                    cpu_resp_valid,
  output logic                    cpu_hit,
  output logic                    tag_write,
  output logic [INDEX_LENGTH-1:0] tag_index,
  output logic [TAG_LENGTH-1:0]   tag_wdata,
  input  logic [TAG_LENGTH-1:0]   tag_rdata,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_ack,
  output logic                    data_write,
  output logic [CNT_WIDTH-1:0]    hit_count,
  output logic [CNT_WIDTH-1:0]    miss_count
);

  cache_state_t                state_q, state_d;
  logic [TAG_LENGTH-1:0]       tag_q;
  logic [INDEX_LENGTH-1:0]     idx_q;
  logic [NUM_CACHE_LINES-1:0]  valid_q;

  logic latch_en;
  logic flush_all;
  logic set_valid;
  logic hit_inc;
  logic miss_inc;
  logic lookup_hit;

  assign lookup_hit = valid_q[idx_q] && (tag_rdata == tag_q);

  // Next-state and output decode. In IDLE the index comes straight from the
  // address bus so tag_mem has the line ready during LOOKUP; everywhere else
  // it is the latched index.
  always_comb begin
    state_d        = state_q;
    cpu_ready      = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_hit        = 1'b0;
    tag_write      = 1'b0;
    data_write     = 1'b0;
    mem_req        = 1'b0;
    tag_index      = idx_q;
    latch_en       = 1'b0;
    flush_all      = 1'b0;
    set_valid      = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        tag_index = addr_index(cpu_addr);
        if (flush) begin
          flush_all = 1'b1;
        end else begin
          cpu_ready = 1'b1;
          if (cpu_req) begin
            latch_en = 1'b1;
            state_d  = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          cpu_resp_valid = 1'b1;
          cpu_hit        = 1'b1;
          hit_inc        = 1'b1;
          state_d        = IDLE;
        end else begin
          miss_inc = 1'b1;
          state_d  = REFILL;
        end
      end
      REFILL: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = UPDATE;
      end
      UPDATE: begin
        tag_write      = 1'b1;
        data_write     = 1'b1;
        set_valid      = 1'b1;
        cpu_resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request address latch; offset is dropped since refills are line-aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
      idx_q <= '0;
    end else if (latch_en) begin
      tag_q <= addr_tag(cpu_addr);
      idx_q <= addr_index(cpu_addr);
    end
  end

  // Valid bits: flush clears every line, a completed refill marks its line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          valid_q <= '0;
    else if (flush_all) valid_q <= '0;
    else if (set_valid) valid_q[idx_q] <= 1'b1;
  end

  assign mem_addr  = {tag_q, idx_q, {OFFSET_LENGTH{1'b0}}};
  assign tag_wdata = tag_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_inc),
    .clear (1'b0),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .clear (1'b0),
    .count (miss_count)
  );

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_dm_cache_ctrl;
  import memory_sub_system_param::*;

  localparam int CW = 4;

  logic                    clk;
  logic                    reset;
  logic                    cpu_req;
  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic                    flush;
  logic                    cpu_ready;
  logic                    cpu_resp_valid;
  logic                    cpu_hit;
  logic                    tag_write;
  logic [INDEX_LENGTH-1:0] tag_index;
  logic [TAG_LENGTH-1:0]   tag_wdata;
  logic [TAG_LENGTH-1:0]   tag_rdata;
  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_ack;
  logic                    data_write;
  logic [CW-1:0]           hit_count;
  logic [CW-1:0]           miss_count;

  int checks   = 0;
  int failures = 0;

  dm_cache_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .flush          (flush),
    .cpu_ready      (cpu_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_hit        (cpu_hit),
    .tag_write      (tag_write),
    .tag_index      (tag_index),
    .tag_wdata      (tag_wdata),
    .tag_rdata      (tag_rdata),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .data_write     (data_write),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // tag_mem stand-in: registered read, written on tag_write.
  logic [TAG_LENGTH-1:0] tmem [NUM_CACHE_LINES];
  initial for (int i = 0; i < NUM_CACHE_LINES; i++) tmem[i] = 8'hA5;
  always @(posedge clk) begin
    if (tag_write) tmem[tag_index] <= tag_wdata;
    tag_rdata <= tmem[tag_index];
  end

  // Main-memory responder: ack after ack_dly cycles of mem_req, optional
  // stray acks while no refill is pending.
  int ack_dly   = 4;
  bit rand_dly  = 1'b0;
  bit stray_ack = 1'b0;
  initial begin
    int ack_cnt;
    ack_cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (reset) ack_cnt = 0;
      else if (mem_req) begin
        if (ack_cnt >= ack_dly) begin
          mem_ack = 1'b1;
          ack_cnt = 0;
          if (rand_dly) ack_dly = $urandom_range(0, 3);
        end else ack_cnt++;
      end else begin
        ack_cnt = 0;
        if (stray_ack && $urandom_range(0, 5) == 0) mem_ack = 1'b1;
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  // One outstanding transaction: its address, whether it hits the model's
  // line table, and where it is in its life (first cycle after accept,
  // waiting on memory, or finishing its refill).
  logic                    m_busy, m_first, m_wait, m_fin, m_hit;
  logic [TAG_LENGTH-1:0]   m_tag;
  logic [INDEX_LENGTH-1:0] m_idx;
  logic [NUM_CACHE_LINES-1:0] m_valid;
  logic [TAG_LENGTH-1:0]   m_tags [NUM_CACHE_LINES];
  logic [CW-1:0]           m_hits, m_misses;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_first <= 1'b0; m_wait <= 1'b0; m_fin <= 1'b0;
      m_hit <= 1'b0; m_tag <= '0; m_idx <= '0; m_valid <= '0;
      m_hits <= '0; m_misses <= '0;
    end else if (!m_busy) begin
      if (flush) m_valid <= '0;
      else if (cpu_req) begin
        m_busy  <= 1'b1;
        m_first <= 1'b1;
        m_tag   <= addr_tag(cpu_addr);
        m_idx   <= addr_index(cpu_addr);
        m_hit   <= m_valid[addr_index(cpu_addr)] &&
                   (m_tags[addr_index(cpu_addr)] == addr_tag(cpu_addr));
      end
    end else if (m_first) begin
      m_first <= 1'b0;
      if (m_hit) begin
        m_busy <= 1'b0;
        m_hits <= sat_inc(m_hits);
      end else begin
        m_misses <= sat_inc(m_misses);
        m_wait   <= 1'b1;
      end
    end else if (m_wait) begin
      if (mem_ack) begin
        m_wait <= 1'b0;
        m_fin  <= 1'b1;
      end
    end else begin
      m_fin          <= 1'b0;
      m_busy         <= 1'b0;
      m_valid[m_idx] <= 1'b1;
      m_tags[m_idx]  <= m_tag;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cpu_ready", cpu_ready, !m_busy && !flush);
      chk("cpu_resp_valid", cpu_resp_valid, m_busy && ((m_first && m_hit) || m_fin));
      chk("cpu_hit", cpu_hit, m_busy && m_first && m_hit);
      chk("mem_req", mem_req, m_wait);
      chk("tag_write", tag_write, m_fin);
      chk("data_write", data_write, m_fin);
      chk("tag_index", tag_index, m_busy ? m_idx : addr_index(cpu_addr));
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);
      if (m_wait) chk("mem_addr", mem_addr, {m_tag, m_idx, 4'h0});
      if (m_fin)  chk("tag_wdata", tag_wdata, m_tag);
    end
  end

  // ---------------- directed helpers ----------------
  logic [ADDR_WIDTH-1:0]   cap_maddr;
  logic [INDEX_LENGTH-1:0] cap_tidx;
  logic [TAG_LENGTH-1:0]   cap_twd;
  bit                      cap_memreq;

  // Issue one request from the "#1 after posedge" phase; returns the
  // response latency in cycles after acceptance and the hit flag.
  task automatic do_req(input logic [7:0] t, input logic [2:0] i,
                        output int lat, output bit hit);
    int  n;
    bit  ok;
    n = 0;
    while (!cpu_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("req_ready_timeout", cpu_ready, 1'b1);
    cpu_req  = 1'b1;
    cpu_addr = {t, i, 4'($urandom)};
    @(posedge clk); #1;
    cpu_req = 1'b0;
    lat = 0; hit = 1'b0; ok = 1'b0; cap_memreq = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      lat++;
      if (mem_req) begin cap_memreq = 1'b1; cap_maddr = mem_addr; end
      if (tag_write) begin cap_tidx = tag_index; cap_twd = tag_wdata; end
      if (cpu_resp_valid) begin hit = cpu_hit; ok = 1'b1; end
    end
    chk("resp_timeout", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit hit;
    int n;
    reset = 1'b0; cpu_req = 1'b0; flush = 1'b0; cpu_addr = '0;
    #1 reset = 1'b1;
    run_cmp = 1'b1;
    @(negedge clk);
    chk("rst_ready", cpu_ready, 1'b1);
    chk("rst_memreq", mem_req, 1'b0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Cold miss: idx 5, tag 0x12, ack 4 cycles after mem_req rises.
    ack_dly = 4;
    do_req(8'h12, 3'd5, lat, hit);
    chk("cold_hit", hit, 1'b0);
    chk("cold_lat", lat, 7);
    chk("cold_maddr", cap_maddr, 15'h0950);
    chk("cold_tidx", cap_tidx, 3'd5);
    chk("cold_twd", cap_twd, 8'h12);
    chk("cold_misses", miss_count, 1);

    // Hit after refill.
    do_req(8'h12, 3'd5, lat, hit);
    chk("hit_hit", hit, 1'b1);
    chk("hit_lat", lat, 1);
    chk("hit_nomemreq", cap_memreq, 1'b0);
    chk("hit_count1", hit_count, 1);

    // Conflict miss, then the evicted tag misses again.
    ack_dly = 1;
    do_req(8'h13, 3'd5, lat, hit);
    chk("conf_hit", hit, 1'b0);
    chk("conf_twd", cap_twd, 8'h13);
    do_req(8'h12, 3'd5, lat, hit);
    chk("evict_hit", hit, 1'b0);

    // Flush together with a request: not accepted, lines invalidated.
    flush = 1'b1; cpu_req = 1'b1; cpu_addr = {8'h12, 3'd5, 4'h0};
    repeat (3) begin
      @(negedge clk);
      chk("flush_ready", cpu_ready, 1'b0);
      chk("flush_noresp", cpu_resp_valid, 1'b0);
      @(posedge clk); #1;
    end
    flush = 1'b0; cpu_req = 1'b0;
    do_req(8'h12, 3'd5, lat, hit);
    chk("post_flush_hit", hit, 1'b0);
    chk("post_flush_misses", miss_count, 4);
    chk("post_flush_hits", hit_count, 1);

    // Reset in the middle of a refill.
    ack_dly = 20;
    cpu_req = 1'b1; cpu_addr = {8'h20, 3'd2, 4'h0};
    @(posedge clk); #1 cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
    chk("mr_memreq_seen", mem_req, 1'b1);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("mr_memreq_drop", mem_req, 1'b0);
    chk("mr_noresp", cpu_resp_valid, 1'b0);
    chk("mr_ready", cpu_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ack_dly = 2;
    do_req(8'h13, 3'd5, lat, hit);
    chk("mr_invalid", hit, 1'b0);
    chk("mr_misses", miss_count, 1);

    // Saturation: 17 hits on a 4-bit counter.
    for (int k = 0; k < 17; k++) begin
      do_req(8'h13, 3'd5, lat, hit);
      chk("sat_each_hit", hit, 1'b1);
    end
    chk("sat_hits", hit_count, 15);

    // Randomized traffic, including stray acks and flushes.
    rand_dly = 1'b1; stray_ack = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      cpu_req  = ($urandom_range(0, 2) != 0);
      cpu_addr = {8'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom)};
      flush    = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; flush = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
